// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : boot_loader
//  Purpose  : Byte-stream program loader placed in front of the polirv core.
//             Takes a framed image (SYNC, word count N, 4*N payload bytes,
//             XOR checksum) on an 8-bit valid/ready stream. It packs the
//             payload little-endian into 32-bit words, writes them into the
//             instruction memory, and releases the core from reset once the
//             checksum matches.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             in_valid/in_data/     - byte stream; a byte transfers when
//             in_ready                in_valid & in_ready
//             ld_we/ld_addr/ld_data - instruction-memory write port
//             core_rst_n            - core reset, high only once loading is done
//             busy                  - a frame is in progress
//             err                   - the last frame had a bad count or checksum
//  Revision : 1.0 - initial release
// ============================================================================
module boot_loader #(
    parameter int          ADDR_W = 6,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ld_we,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [31:0]       ld_data,
    output logic              core_rst_n,
    output logic              busy,
    output logic              err
);

    // Word counters need one extra bit so that a full 2**ADDR_W image fits.
    localparam int          c_cnt_w = ADDR_W + 1;
    localparam logic [31:0] c_cap   = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_LOAD  = 3'd2,
        S_CSUM  = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic                 w_accept;
    logic                 w_is_sync;
    logic [31:0]          w_byte_ext;
    logic                 w_count_ok;
    logic                 w_word_done;
    logic                 w_last_word;
    logic [c_cnt_w-1:0]   w_word_inc;

    logic [1:0]           r_byte_cnt;
    logic [c_cnt_w-1:0]   r_word_cnt;
    logic [c_cnt_w-1:0]   r_n;
    logic [7:0]           r_csum;
    logic [23:0]          r_word;
    logic                 r_ld_we;
    logic [ADDR_W-1:0]    r_ld_addr;
    logic [31:0]          r_ld_data;
    logic                 r_core_rst_n;
    logic                 r_err;

    assign in_ready    = (r_state != S_RUN);
    assign busy        = (r_state == S_COUNT) || (r_state == S_LOAD) ||
                         (r_state == S_CSUM);
    assign w_accept    = in_valid & in_ready;
    assign w_is_sync   = (in_data == SYNC);
    assign w_byte_ext  = {24'd0, in_data};
    assign w_count_ok  = (w_byte_ext != 32'd0) && (w_byte_ext <= c_cap);
    assign w_word_done = (r_byte_cnt == 2'd3);
    assign w_word_inc  = r_word_cnt + c_cnt_w'(1);
    // The checksum byte follows directly after the last payload byte.
    assign w_last_word = w_word_done && (w_word_inc == r_n);

    assign ld_we      = r_ld_we;
    assign ld_addr    = r_ld_addr;
    assign ld_data    = r_ld_data;
    assign core_rst_n = r_core_rst_n;
    assign err        = r_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; every transition is triggered by an accepted byte
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            case (r_state)
                S_IDLE:  if (w_is_sync) w_next_state = S_COUNT;
                S_COUNT: w_next_state = w_count_ok ? S_LOAD : S_ERROR;
                S_LOAD:  if (w_last_word) w_next_state = S_CSUM;
                S_CSUM:  w_next_state = (in_data == r_csum) ? S_RUN : S_ERROR;
                S_RUN:   w_next_state = S_RUN;
                S_ERROR: if (w_is_sync) w_next_state = S_COUNT;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: word assembly, memory write port, checksum, status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt   <= 2'd0;
            r_word_cnt   <= '0;
            r_n          <= '0;
            r_csum       <= 8'd0;
            r_word       <= 24'd0;
            r_ld_we      <= 1'b0;
            r_ld_addr    <= '0;
            r_ld_data    <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ld_we      <= 1'b0;
            r_core_rst_n <= (w_next_state == S_RUN);
            if (w_accept) begin
                case (r_state)
                    S_COUNT: begin
                        r_n        <= w_byte_ext[c_cnt_w-1:0];
                        r_word_cnt <= '0;
                        r_byte_cnt <= 2'd0;
                        r_csum     <= 8'd0;
                        if (!w_count_ok) r_err <= 1'b1;
                    end
                    S_LOAD: begin
                        r_csum     <= r_csum ^ in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Shift right so the first byte ends up in the low lane.
                        r_word     <= {in_data, r_word[23:8]};
                        if (w_word_done) begin
                            // Write port is driven from dedicated registers so the
                            // next word can start assembling during the strobe.
                            r_ld_we    <= 1'b1;
                            r_ld_addr  <= r_word_cnt[ADDR_W-1:0];
                            r_ld_data  <= {in_data, r_word};
                            r_word_cnt <= w_word_inc;
                        end
                    end
                    S_CSUM: begin
                        if (in_data != r_csum) r_err <= 1'b1;
                    end
                    S_ERROR: begin
                        if (w_is_sync) r_err <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boot_loader
//  Purpose  : Self-checking bench for boot_loader. Frames are built with
//             random payloads, parsed by a byte-stream reference model, and
//             the observed memory writes and status flags are compared.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    localparam int         ADDR_W = 6;
    localparam logic [7:0] SYNC   = 8'hA5;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              core_rst_n;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    int ready_drops = 0;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    bit                m_err;
    bit                m_run;

    boot_loader #(.ADDR_W(ADDR_W), .SYNC(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1);
    end

    // Capture every memory write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n && ld_we === 1'b1) begin
            got_addr.push_back(ld_addr);
            got_data.push_back(ld_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: scan the byte stream frame by frame. Bytes outside a
    // frame are ignored until SYNC; a bad count or checksum flags an error;
    // once the core is released nothing further is consumed.
    task automatic model_stream(input byte_q_t s);
        int          i;
        int          n;
        int          k;
        logic [7:0]  cs;
        i = 0;
        while (i < s.size() && !m_run) begin
            if (s[i] != SYNC) begin
                i++;
                continue;
            end
            m_err = 1'b0;
            i++;
            if (i >= s.size()) break;
            n = int'(s[i]);
            i++;
            if (n < 1 || n > (1 << ADDR_W)) begin
                m_err = 1'b1;
                continue;
            end
            cs = 8'd0;
            k  = 0;
            while (k < n && i + 3 < s.size()) begin
                exp_addr.push_back(ADDR_W'(k));
                exp_data.push_back({s[i+3], s[i+2], s[i+1], s[i]});
                cs = cs ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                i += 4;
                k++;
            end
            if (k < n || i >= s.size()) break;
            if (s[i] == cs) m_run = 1'b1;
            else            m_err = 1'b1;
            i++;
        end
    endtask

    task automatic build_frame(output byte_q_t s, input int n, input bit good,
                               input bit force_sync);
        logic [7:0] cs;
        logic [7:0] b;
        s = {};
        s.push_back(SYNC);
        s.push_back(8'(n));
        cs = 8'd0;
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            if (force_sync && k == 0) b = SYNC;
            cs ^= b;
            s.push_back(b);
        end
        if (!good) cs ^= 8'($urandom_range(1, 255));
        s.push_back(cs);
    endtask

    // Drive one byte starting at a falling edge; it transfers on the next
    // rising edge if in_ready is high. Optional idle gaps carry junk data.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        g = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        if (!in_ready) ready_drops++;
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic send_stream(input byte_q_t s, input bit gaps);
        foreach (s[i]) send_byte(s[i], gaps);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd1);
        check({tag, "_ld_we"},      32'(ld_we),      32'd0);
        check({tag, "_ld_addr"},    32'(ld_addr),    32'd0);
        check({tag, "_ld_data"},    ld_data,         32'd0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
    endtask

    task automatic apply_reset(input bit check_vals);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        if (check_vals) check_reset_vals("reset");
        rst_n = 1'b1;
        got_addr = {};
        got_data = {};
        exp_addr = {};
        exp_data = {};
        m_err = 1'b0;
        m_run = 1'b0;
        ready_drops = 0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
        got_addr = {};
        got_data = {};
        exp_addr = {};
        exp_data = {};
    endtask

    task automatic compare_status(input string tag);
        check({tag, "_err"},        32'(err),        32'(m_err));
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(m_run));
        check({tag, "_in_ready"},   32'(in_ready),   32'(!m_run));
        check({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        byte_q_t s;
        byte_q_t part;

        // 1: single-word frame with exact strobe and release timing
        apply_reset(1'b1);
        s = '{SYNC, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        model_stream(s);
        for (int i = 0; i < 6; i++) send_byte(s[i], 1'b0);
        send_byte(s[6], 1'b0);
        check("s1_we_pulse",     32'(ld_we),      32'd1);
        check("s1_we_addr",      32'(ld_addr),    32'd0);
        check("s1_we_data",      ld_data,         32'h0000_0013);
        check("s1_core_before",  32'(core_rst_n), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("s1_core_after",   32'(core_rst_n), 32'd1);
        check("s1_we_single",    32'(ld_we),      32'd0);
        repeat (2) @(negedge clk);
        compare_writes("s1");
        compare_status("s1");

        // 2: three words back-to-back with no idle cycles
        apply_reset(1'b0);
        build_frame(s, 3, 1'b1, 1'b0);
        model_stream(s);
        send_stream(s, 1'b0);
        check("s2_ready_drops", 32'(ready_drops), 32'd0);
        compare_writes("s2");
        compare_status("s2");

        // 3: bad checksum, then a good frame without reset
        apply_reset(1'b0);
        build_frame(s, int'($urandom_range(1, 8)), 1'b0, 1'b0);
        model_stream(s);
        send_stream(s, 1'b1);
        compare_writes("s3_bad");
        compare_status("s3_bad");
        build_frame(s, int'($urandom_range(1, 8)), 1'b1, 1'b0);
        model_stream(s);
        send_stream(s, 1'b1);
        compare_writes("s3_good");
        compare_status("s3_good");

        // 4: garbage in IDLE, then counts 0 and 65
        apply_reset(1'b0);
        s = '{8'h11, 8'h22};
        model_stream(s);
        send_stream(s, 1'b0);
        compare_status("s4_garbage");
        s = '{SYNC, 8'h00};
        model_stream(s);
        send_stream(s, 1'b0);
        compare_writes("s4_n0");
        compare_status("s4_n0");
        s = '{8'h33, SYNC, 8'd65};
        model_stream(s);
        send_stream(s, 1'b1);
        compare_writes("s4_n65");
        compare_status("s4_n65");

        // 5: full 64-word image
        apply_reset(1'b0);
        build_frame(s, 64, 1'b1, 1'b0);
        model_stream(s);
        send_stream(s, 1'b1);
        if (got_addr.size() > 0) check("s5_last_addr", 32'(got_addr[$]), 32'd63);
        compare_writes("s5");
        compare_status("s5");

        // 6: asynchronous reset mid-frame, then a fresh frame
        apply_reset(1'b0);
        build_frame(s, 2, 1'b1, 1'b0);
        part = s[0:7];
        model_stream(part);
        send_stream(part, 1'b0);
        compare_writes("s6_pre");
        check("s6_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("s6_async");
        apply_reset(1'b0);
        build_frame(s, 2, 1'b1, 1'b0);
        model_stream(s);
        send_stream(s, 1'b1);
        compare_writes("s6_post");
        compare_status("s6_post");

        // Random frames, some with SYNC as the first payload byte
        for (int r = 0; r < 4; r++) begin
            apply_reset(1'b0);
            build_frame(s, int'($urandom_range(1, 16)), 1'b1, r[0]);
            model_stream(s);
            send_stream(s, 1'b1);
            compare_writes($sformatf("rnd%0d", r));
            compare_status($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
